mem_arbiter: RTL and testbench

- Two-master, one-slave arbiter on the PicoRV32 native memory interface.
- Shares a single memory between the multi-cycle CPU core (master 0) and a second requester such as a program loader or debug port (master 1).
- Grants are round-robin. A grant is held until the transfer completes.
- A watchdog ends any transfer the slave never acknowledges, returns an error word and records the failing address.

---
 rtl/mem_bus_pkg.sv | 35 +++
 rtl/mem_bus_if.sv | 28 ++
 rtl/mem_wdog.sv | 54 +++++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
// ----------------------------------------------------------------------------
// mem_bus_pkg
//   Shared types and constants for the PicoRV32 native memory bus.
//   - MEM_ADDR_W / MEM_DATA_W / MEM_STRB_W : native bus field widths
//   - arb_state_t : arbiter FSM states
//   - mem_req_t   : one master's request (valid, instr, addr, wdata, wstrb)
//   - wdog_cnt_w  : watchdog counter width for a given timeout
// ----------------------------------------------------------------------------
package mem_bus_pkg;

   localparam int MEM_ADDR_W = 32;
   localparam int MEM_DATA_W = 32;
   localparam int MEM_STRB_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic                  valid;
      logic                  instr;
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_DATA_W-1:0] wdata;
      logic [MEM_STRB_W-1:0] wstrb;
   } mem_req_t;

   // A disabled watchdog (timeout 0) still gets a 1-bit counter so that
   // no zero-width vectors appear.
   function automatic int wdog_cnt_w(input int unsigned timeout);
      return (timeout > 0) ? $clog2(timeout + 1) : 1;
   endfunction

endpackage

// File: rtl/mem_bus_if.sv
// ----------------------------------------------------------------------------
// mem_bus_if
//   One PicoRV32 native memory bus link.
//   master modport : drives valid/instr/addr/wdata/wstrb, receives ready/rdata
//   slave  modport : receives the request, drives ready/rdata
// ----------------------------------------------------------------------------
interface mem_bus_if;
   import mem_bus_pkg::*;

   logic                  valid;
   logic                  instr;
   logic [MEM_ADDR_W-1:0] addr;
   logic [MEM_DATA_W-1:0] wdata;
   logic [MEM_STRB_W-1:0] wstrb;
   logic                  ready;
   logic [MEM_DATA_W-1:0] rdata;

   modport master (
      output valid, instr, addr, wdata, wstrb,
      input  ready, rdata
   );

   modport slave (
      input  valid, instr, addr, wdata, wstrb,
      output ready, rdata
   );

endinterface

// File: rtl/mem_wdog.sv
// ----------------------------------------------------------------------------
// mem_wdog
//   Transfer watchdog: counts granted cycles without mem_ready and flags the
//   cycle on which the transfer must be aborted.
//   clk       in  : clock
//   reset_n   in  : synchronous active-low reset
//   clear     in  : hold the counter at zero (arbiter idle)
//   active    in  : a grant is in progress
//   mem_ready in  : slave acknowledge
//   timeout   out : combinational abort pulse (count reached, no ready)
// ----------------------------------------------------------------------------
module mem_wdog
   import mem_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic active,
   input  logic mem_ready,
   output logic timeout
);

   localparam int              CNT_W = wdog_cnt_w(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] wd_cnt_reg;
   logic [CNT_W-1:0] wd_cnt_next;

   // Holding the count at zero while idle is the same as clearing it on
   // grant entry. Counting stops at LIMIT so the counter never wraps; with
   // TIMEOUT_CYCLES = 0 LIMIT is 0 and the counter never moves.
   always_comb begin
      wd_cnt_next = wd_cnt_reg;
      if (clear) begin
         wd_cnt_next = '0;
      end else if (active && !mem_ready && (wd_cnt_reg != LIMIT)) begin
         wd_cnt_next = wd_cnt_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wd_cnt_reg <= '0;
      end else begin
         wd_cnt_reg <= wd_cnt_next;
      end
   end

   assign timeout = (TIMEOUT_CYCLES != 0) && active && !mem_ready &&
                    (wd_cnt_reg == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//   Two-master, one-slave round-robin arbiter for the PicoRV32 native bus.
//   A grant is held until the slave acknowledges or the watchdog expires;
//   every transfer is followed by at least one idle cycle.
//   clk        in  : clock
//   reset_n    in  : synchronous active-low reset
//   m0, m1     slave modports  : requesting masters (m0 = CPU core)
//   mem        master modport  : shared memory
//   grant      out [1:0] : one-hot owner, 2'b00 when idle
//   err        out       : sticky timeout flag
//   err_clear  in        : clears err (a new timeout in the same cycle wins)
//   err_addr   out [31:0]: address of the most recent timed-out transfer
// ----------------------------------------------------------------------------
module mem_arbiter
   import mem_bus_pkg::*;
#(
   parameter int unsigned           TIMEOUT_CYCLES = 255,
   parameter logic [MEM_DATA_W-1:0] ERR_DATA       = 32'hDEADBEEF
) (
   input  logic                  clk,
   input  logic                  reset_n,
   mem_bus_if.slave              m0,
   mem_bus_if.slave              m1,
   mem_bus_if.master             mem,
   output logic [1:0]            grant,
   output logic                  err,
   input  logic                  err_clear,
   output logic [MEM_ADDR_W-1:0] err_addr
);

   arb_state_t            state_reg;
   arb_state_t            state_next;
   logic                  last_grant_reg;   // 0: m0 was granted last, 1: m1
   logic                  err_reg;
   logic [MEM_ADDR_W-1:0] err_addr_reg;

   mem_req_t              req_sel;
   logic                  rsp_ready;
   logic [MEM_DATA_W-1:0] rsp_rdata;
   logic                  wd_active;
   logic                  timeout;

   assign wd_active = (state_reg != IDLE);

   mem_wdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wdog (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (!wd_active),
      .active    (wd_active),
      .mem_ready (mem.ready),
      .timeout   (timeout)
   );

   // ---------------------------------------------------------------------
   // Next state and routing
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      req_sel    = '0;
      grant      = 2'b00;

      unique case (state_reg)
         IDLE: begin
            // mem_ready is ignored here; the winner of a tie is the master
            // that was not served last.
            if (m0.valid && m1.valid) begin
               state_next = last_grant_reg ? GRANT0 : GRANT1;
            end else if (m0.valid) begin
               state_next = GRANT0;
            end else if (m1.valid) begin
               state_next = GRANT1;
            end
         end
         GRANT0: begin
            grant   = 2'b01;
            req_sel = '{valid: m0.valid, instr: m0.instr, addr: m0.addr,
                        wdata: m0.wdata, wstrb: m0.wstrb};
            if (mem.ready || timeout) begin
               state_next = IDLE;
            end
         end
         GRANT1: begin
            grant   = 2'b10;
            req_sel = '{valid: m1.valid, instr: m1.instr, addr: m1.addr,
                        wdata: m1.wdata, wstrb: m1.wstrb};
            if (mem.ready || timeout) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // timeout is only raised while mem_ready is low, so the slave
      // response always wins a coincident timeout.
      rsp_ready = wd_active && (mem.ready || timeout);
      rsp_rdata = timeout ? ERR_DATA : mem.rdata;

      mem.valid = req_sel.valid && !timeout;
      mem.instr = req_sel.instr;
      mem.addr  = req_sel.addr;
      mem.wdata = req_sel.wdata;
      mem.wstrb = req_sel.wstrb;

      // A reset that lands mid-transfer must not complete it, so readies
      // are suppressed while reset_n is low.
      m0.ready = grant[0] && rsp_ready && reset_n;
      m0.rdata = grant[0] ? rsp_rdata : '0;
      m1.ready = grant[1] && rsp_ready && reset_n;
      m1.rdata = grant[1] ? rsp_rdata : '0;
   end

   // ---------------------------------------------------------------------
   // State, round-robin pointer, error capture
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         last_grant_reg <= 1'b1;
         err_reg        <= 1'b0;
         err_addr_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && state_next == GRANT0) begin
            last_grant_reg <= 1'b0;
         end else if (state_reg == IDLE && state_next == GRANT1) begin
            last_grant_reg <= 1'b1;
         end
         if (timeout) begin
            err_reg      <= 1'b1;
            err_addr_reg <= req_sel.addr;
         end else if (err_clear) begin
            err_reg <= 1'b0;
         end
      end
   end

   assign err      = err_reg;
   assign err_addr = err_addr_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter with TIMEOUT_CYCLES = 4. Inputs change
//   1 time unit after the rising edge, outputs are sampled 2 units after it.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;
   import mem_bus_pkg::*;

   localparam int unsigned T = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        err_clear;
   logic [1:0]  grant;
   logic        err;
   logic [31:0] err_addr;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   mem_bus_if m0_bus ();
   mem_bus_if m1_bus ();
   mem_bus_if mem_bus ();

   mem_arbiter #(
      .TIMEOUT_CYCLES (T),
      .ERR_DATA       (32'hDEADBEEF)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .m0        (m0_bus),
      .m1        (m1_bus),
      .mem       (mem_bus),
      .grant     (grant),
      .err       (err),
      .err_clear (err_clear),
      .err_addr  (err_addr)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m0(input logic v, input logic ins, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
      m0_bus.valid = v; m0_bus.instr = ins; m0_bus.addr = a;
      m0_bus.wdata = wd; m0_bus.wstrb = ws;
   endtask

   task automatic set_m1(input logic v, input logic ins, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
      m1_bus.valid = v; m1_bus.instr = ins; m1_bus.addr = a;
      m1_bus.wdata = wd; m1_bus.wstrb = ws;
   endtask

   task automatic set_slave(input logic rdy, input logic [31:0] rd);
      mem_bus.ready = rdy;
      mem_bus.rdata = rd;
   endtask

   // Leaves the bench 1 unit after an edge with reset released: the current
   // cycle is the first IDLE cycle and new requests are sampled at the next edge.
   task automatic do_reset();
      reset_n   = 1'b0;
      err_clear = 1'b0;
      set_m0(0, 0, 0, 0, 0);
      set_m1(0, 0, 0, 0, 0);
      set_slave(0, 0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL tb_watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [1:0] exp_grant [5];
      exp_grant = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

      // ---------------- reset state ----------------
      reset_n   = 1'b0;
      err_clear = 1'b0;
      set_m0(0, 0, 0, 0, 0);
      set_m1(0, 0, 0, 0, 0);
      set_slave(0, 0);
      repeat (2) @(posedge clk);
      #2;
      check_val("rst_grant",    32'(grant),        32'h0);
      check_val("rst_err",      32'(err),          32'h0);
      check_val("rst_err_addr", err_addr,          32'h0);
      check_val("rst_mem_valid",32'(mem_bus.valid),32'h0);
      check_val("rst_m0_ready", 32'(m0_bus.ready), 32'h0);
      check_val("rst_m1_ready", 32'(m1_bus.ready), 32'h0);

      // ---------------- single m0 read ----------------
      do_reset();
      set_m0(1, 1, 32'h100, 0, 0);
      #1;
      check_val("s1_idle_grant", 32'(grant),         32'h0);
      check_val("s1_idle_valid", 32'(mem_bus.valid), 32'h0);
      tick();
      set_slave(1, 32'h00500093);
      #1;
      check_val("s1_grant",     32'(grant),         32'h1);
      check_val("s1_mem_valid", 32'(mem_bus.valid), 32'h1);
      check_val("s1_mem_addr",  mem_bus.addr,       32'h100);
      check_val("s1_mem_instr", 32'(mem_bus.instr), 32'h1);
      check_val("s1_mem_wstrb", 32'(mem_bus.wstrb), 32'h0);
      check_val("s1_m0_ready",  32'(m0_bus.ready),  32'h1);
      check_val("s1_m0_rdata",  m0_bus.rdata,       32'h00500093);
      check_val("s1_m1_ready",  32'(m1_bus.ready),  32'h0);
      check_val("s1_m1_rdata",  m1_bus.rdata,       32'h0);
      $display("txn s1 m0 read addr=%h rdata=%h", mem_bus.addr, m0_bus.rdata);
      tick();
      set_m0(0, 0, 0, 0, 0);
      set_slave(0, 0);
      #1;
      check_val("s1_after_grant", 32'(grant),        32'h0);
      check_val("s1_after_ready", 32'(m0_bus.ready), 32'h0);

      // ---------------- simultaneous requests ----------------
      do_reset();
      set_m0(1, 0, 32'h10, 0, 0);
      set_m1(1, 0, 32'h20, 0, 0);
      set_slave(1, 32'h11);
      #1;
      check_val("s2_c0_grant", 32'(grant), 32'h0);
      for (int i = 0; i < 5; i++) begin
         tick();
         #1;
         check_val($sformatf("s2_c%0d_grant", i + 1), 32'(grant), 32'(exp_grant[i]));
         if (exp_grant[i] == 2'b01) begin
            check_val("s2_m0_ready", 32'(m0_bus.ready), 32'h1);
            check_val("s2_m0_addr",  mem_bus.addr,      32'h10);
            $display("txn s2 grant m0 addr=%h", mem_bus.addr);
         end else if (exp_grant[i] == 2'b10) begin
            check_val("s2_m1_ready", 32'(m1_bus.ready), 32'h1);
            check_val("s2_m1_addr",  mem_bus.addr,      32'h20);
            $display("txn s2 grant m1 addr=%h", mem_bus.addr);
         end
      end

      // ---------------- m1 write with m0 waiting ----------------
      do_reset();
      set_m1(1, 0, 32'h200, 32'hCAFEF00D, 4'b1111);
      #1;
      check_val("s3_idle_grant", 32'(grant), 32'h0);
      for (int k = 0; k < 3; k++) begin
         tick();
         if (k == 0) set_m0(1, 0, 32'h44, 0, 0);
         if (k == 2) set_slave(1, 32'h0);
         #1;
         check_val("s3_grant",     32'(grant),         32'h2);
         check_val("s3_mem_valid", 32'(mem_bus.valid), 32'h1);
         check_val("s3_mem_addr",  mem_bus.addr,       32'h200);
         check_val("s3_mem_wdata", mem_bus.wdata,      32'hCAFEF00D);
         check_val("s3_mem_wstrb", 32'(mem_bus.wstrb), 32'hF);
         check_val("s3_m0_ready",  32'(m0_bus.ready),  32'h0);
         check_val("s3_m1_ready",  32'(m1_bus.ready),  (k == 2) ? 32'h1 : 32'h0);
      end
      $display("txn s3 m1 write addr=%h wdata=%h", mem_bus.addr, mem_bus.wdata);
      tick();
      set_m1(0, 0, 0, 0, 0);
      set_slave(0, 0);
      #1;
      check_val("s3_gap_grant",    32'(grant),        32'h0);
      check_val("s3_gap_m0_ready", 32'(m0_bus.ready), 32'h0);
      tick();
      #1;
      check_val("s3_m0_grant", 32'(grant),   32'h1);
      check_val("s3_m0_addr",  mem_bus.addr, 32'h44);

      // ---------------- timeout ----------------
      do_reset();
      set_m0(1, 0, 32'h3000, 0, 0);
      #1;
      check_val("s4_idle_valid", 32'(mem_bus.valid), 32'h0);
      for (int c = 1; c <= 5; c++) begin
         tick();
         #1;
         if (c <= int'(T)) begin
            check_val($sformatf("s4_c%0d_valid", c), 32'(mem_bus.valid), 32'h1);
            check_val($sformatf("s4_c%0d_ready", c), 32'(m0_bus.ready),  32'h0);
         end else begin
            check_val("s4_to_valid", 32'(mem_bus.valid), 32'h0);
            check_val("s4_to_ready", 32'(m0_bus.ready),  32'h1);
            check_val("s4_to_rdata", m0_bus.rdata,       32'hDEADBEEF);
            check_val("s4_to_err",   32'(err),           32'h0);
            $display("txn s4 m0 timeout addr=%h rdata=%h", mem_bus.addr, m0_bus.rdata);
         end
      end
      tick();
      set_m0(0, 0, 0, 0, 0);
      err_clear = 1'b1;
      #1;
      check_val("s4_err_set",  32'(err),   32'h1);
      check_val("s4_err_addr", err_addr,   32'h3000);
      check_val("s4_idle",     32'(grant), 32'h0);
      tick();
      err_clear = 1'b0;
      #1;
      check_val("s4_err_clr",      32'(err), 32'h0);
      check_val("s4_err_addr_kept", err_addr, 32'h3000);

      // ---------------- ready exactly on grant cycle T+1 ----------------
      do_reset();
      set_m1(1, 0, 32'h500, 0, 0);
      #1;
      for (int c = 1; c <= 5; c++) begin
         tick();
         if (c == 5) set_slave(1, 32'h12345678);
         #1;
         check_val($sformatf("s5_c%0d_valid", c), 32'(mem_bus.valid), 32'h1);
      end
      check_val("s5_m1_ready", 32'(m1_bus.ready), 32'h1);
      check_val("s5_m1_rdata", m1_bus.rdata,      32'h12345678);
      $display("txn s5 m1 late read addr=%h rdata=%h", mem_bus.addr, m1_bus.rdata);
      tick();
      set_m1(0, 0, 0, 0, 0);
      set_slave(0, 0);
      #1;
      check_val("s5_err",   32'(err),   32'h0);
      check_val("s5_grant", 32'(grant), 32'h0);

      // ---------------- reset during GRANT1 ----------------
      do_reset();
      set_m1(1, 0, 32'h600, 0, 0);
      #1;
      tick();
      #1;
      check_val("s6_grant",     32'(grant),         32'h2);
      check_val("s6_mem_valid", 32'(mem_bus.valid), 32'h1);
      tick();
      reset_n = 1'b0;
      #1;
      tick();
      #1;
      check_val("s6_rst_valid",    32'(mem_bus.valid), 32'h0);
      check_val("s6_rst_grant",    32'(grant),         32'h0);
      check_val("s6_rst_m1_ready", 32'(m1_bus.ready),  32'h0);
      $display("txn s6 m1 aborted by reset addr=%h", m1_bus.addr);
      reset_n = 1'b1;
      set_m1(0, 0, 0, 0, 0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
